// File: rtl/mul_pkg.sv
// Shared types and helpers for the repeated-addition multiplier.
// The sign/magnitude helper is used when MUL_RPT_SIGNED_EN is defined.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Magnitude of a w-bit two's complement value; -2^(w-1) maps to 2^(w-1).
  function automatic logic [63:0] mag_of(input logic [63:0] v,
                                         input int          w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    if (v[w-1])
      return ((~v) + 64'd1) & m;
    return v & m;
  endfunction

endpackage

// File: rtl/mul_rpt_ctr.sv
// Loadable WIDTH-bit down-counter with zero flag.
// Decrement is suppressed at zero so the count never wraps.
module mul_rpt_ctr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !zero)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/mul_rpt_add_seq.sv
// Sequential multiplier by repeated addition with start/busy/done.
// Define MUL_RPT_SIGNED_EN for two's complement operands and product.
module mul_rpt_add_seq
  import mul_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit MIN_SWAP = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [WIDTH-1:0]          a_in,
  input  logic [WIDTH-1:0]          b_in,
  output logic                      busy,
  output logic                      done,
  output logic [prod_w(WIDTH)-1:0]  product
);

  localparam int PW = prod_w(WIDTH);

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] ld_add;
  logic [WIDTH-1:0] ld_cnt;
  logic [WIDTH-1:0] cnt;
  logic             cnt_zero;
  logic             accept;
  logic             step;
  logic             swap;

`ifdef MUL_RPT_SIGNED_EN
  logic neg;

  assign a_mag  = WIDTH'(mag_of(64'(a_in), WIDTH));
  assign b_mag  = WIDTH'(mag_of(64'(b_in), WIDTH));
  assign result = neg ? (~acc + PW'(1)) : acc;

  always_ff @(posedge clk) begin
    if (!rst_n)
      neg <= 1'b0;
    else if (accept)
      neg <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
  end
`else
  assign a_mag  = a_in;
  assign b_mag  = b_in;
  assign result = acc;
`endif

  // Count down the smaller magnitude; a tie keeps b as the counter.
  assign swap   = MIN_SWAP && (a_mag < b_mag);
  assign ld_cnt = swap ? a_mag : b_mag;
  assign ld_add = swap ? b_mag : a_mag;

  assign accept = (state == IDLE) && start;
  assign step   = (state == ADD) && !abort && !cnt_zero;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  mul_rpt_ctr #(
    .WIDTH (WIDTH)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .dec      (step),
    .load_val (ld_cnt),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      addend  <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            addend <= ld_add;
            state  <= ADD;
          end
        end
        ADD: begin
          if (abort) begin
            state <= IDLE;
          end else if (cnt_zero) begin
            product <= result;
            state   <= DONE;
          end else begin
            acc <= acc + PW'(addend);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rpt_add_seq.sv
// Randomised self-checking bench for mul_rpt_add_seq.
// Build with MUL_RPT_SIGNED_EN to exercise the signed variant.
`timescale 1ns/1ps
module tb_mul_rpt_add_seq;

`ifdef MUL_RPT_SIGNED_EN
  localparam int W = 8;
`else
  localparam int W = 16;
`endif
  localparam bit SWAP = 1'b1;
  localparam int PW   = 2 * W;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  a_in  = '0;
  logic [W-1:0]  b_in  = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_rpt_add_seq #(
    .WIDTH    (W),
    .MIN_SWAP (SWAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sval(input logic [W-1:0] v);
`ifdef MUL_RPT_SIGNED_EN
    return longint'($signed(v));
`else
    return longint'(v);
`endif
  endfunction

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint      p;
    logic [63:0] r;
    p = sval(a) * sval(b);
    r = p;
    return r & ((64'd1 << PW) - 64'd1);
  endfunction

  function automatic longint ref_n(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    longint ma, mb;
    ma = sval(a) < 0 ? -sval(a) : sval(a);
    mb = sval(b) < 0 ? -sval(b) : sval(b);
    if (SWAP && ma < mb)
      return ma;
    return mb;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    longint      n;
    logic [63:0] e;
    int          c;
    n = ref_n(a, b);
    e = ref_prod(a, b);
    c = 0;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    chk("busy_after_accept", busy, 1);
    while (!done && c < 70000) begin
      tick();
      c++;
    end
    chk("latency", c, n + 1);
    chk("product", product, e);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  logic [63:0] held;
  logic [W-1:0] x, y;
  int c, pulses;

  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;
    tick();

`ifdef MUL_RPT_SIGNED_EN
    run_op(8'h80, 8'h03);
    chk("neg128x3", product, 16'hFE80);
    run_op(8'hFB, 8'hF9);
    chk("m5xm7", product, 16'd35);
    run_op(8'h00, 8'hFF);
    chk("0xm1", product, 16'd0);
    run_op(8'h03, 8'h7F);
`else
    run_op(16'd3, 16'd1000);
    chk("3x1000", product, 32'd3000);
    run_op(16'hFFFF, 16'd0);
    chk("ffff_x0", product, 32'd0);
    run_op(16'd3, 16'd1000);
`endif

    // reset in the middle of an ADD sequence
    a_in  = W'(200);
    b_in  = W'(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (150) begin
      tick();
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);

    // abort in the third ADD cycle, stray start while busy
    run_op(W'(11), W'(4));
    held  = product;
    a_in  = W'(7);
    b_in  = W'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_product", product, held);
    pulses = 0;
    repeat (20) begin
      tick();
      if (done || busy) pulses++;
    end
    chk("abort_quiet", pulses, 0);
    chk("abort_product_hold", product, held);

    // back-to-back with start held high
    a_in  = W'(5);
    b_in  = W'(6);
    start = 1'b1;
    tick();
    c = 0;
    while (!done && c < 100) begin
      tick();
      c++;
    end
    chk("b2b_lat1", c, 6);
    chk("b2b_p1", product, 30);
    a_in = W'(2);
    b_in = W'(0);
    tick();
    chk("b2b_idle", busy, 0);
    tick();
    chk("b2b_accept", busy, 1);
    c = 0;
    while (!done && c < 100) begin
      tick();
      c++;
    end
    chk("b2b_lat2", c, 1);
    chk("b2b_p2", product, 0);
    start = 1'b0;
    tick();
    chk("b2b_done_drop", done, 0);
    tick();
    chk("b2b_stays_idle", busy, 0);

    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      y = W'($urandom_range(0, 300));
      if ($urandom_range(0, 1) == 1)
        run_op(x, y);
      else
        run_op(y, x);
    end

`ifndef MUL_RPT_SIGNED_EN
    run_op(16'hFFFF, 16'hFFFF);
    chk("max_product", product, 32'hFFFE0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
